ttc_frame_scheduler: RTL and testbench

- Schedules the single outgoing TTC link between three sources: trigger requests, queued fast commands, and periodic sync frames. Idle frames fill any remaining slots.
- Emits one 16-bit frame per accepted transfer to the downstream link serializer over a valid/ready handshake.
- Sits between the 40 MHz trigger/command generation logic (already resynchronised into clk160) and the TTC serializer feeding ttc_data_p/n.

---
 rtl/ttc_frame_scheduler.sv | 126 ++++++++++++
 tb/tb_ttc_frame_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ttc_frame_scheduler.sv
// ttc_frame_scheduler: arbitrates the outgoing TTC frame slot between triggers, queued commands and periodic sync
//
// Ports:
//   clk160        sole clock
//   rst_n         asynchronous active-low reset
//   trig_in       trigger request, one request per high cycle
//   cmd_valid     command word offered
//   cmd_data      12-bit command payload
//   cmd_ready     command FIFO can accept (not full)
//   out_data      16-bit frame to the serializer
//   out_valid     out_data valid (high from the first edge after reset)
//   out_ready     serializer accepts out_data
//   trig_pending  triggers accepted but not yet framed
//   trig_overflow sticky flag: a trigger was dropped
module ttc_frame_scheduler #(
    parameter int CMD_DEPTH      = 4,
    parameter int SYNC_INTERVAL  = 32,
    parameter int MAX_TRIG_BURST = 4
) (
    input  logic        clk160,
    input  logic        rst_n,
    input  logic        trig_in,
    input  logic        cmd_valid,
    input  logic [11:0] cmd_data,
    output logic        cmd_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  trig_pending,
    output logic        trig_overflow
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(CMD_DEPTH + 1);
    localparam int SW = $clog2(SYNC_INTERVAL + 1);
    localparam int BW = $clog2(MAX_TRIG_BURST + 1);

    typedef enum logic [1:0] {F_IDLE, F_TRIG, F_CMD, F_SYNC} frame_e;

    frame_e        state_q, state_d, sel;
    logic [11:0]   mem_q [CMD_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] sync_q, sync_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [7:0]    tag_q, tag_d;
    logic [3:0]    pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          valid_q;
    logic [15:0]   data_q, data_d;
    logic          load, push, pop, fifo_empty, trig_load;

    always_comb begin
        // The very first edge after reset loads a frame even though nothing is valid yet
        load       = !valid_q || out_ready;
        fifo_empty = count_q == '0;
        cmd_ready  = count_q != CW'(CMD_DEPTH);
        push       = cmd_valid && cmd_ready;
        // Burst limit gives a waiting command one slot after MAX_TRIG_BURST consecutive triggers
        sel = (burst_q == BW'(MAX_TRIG_BURST) && !fifo_empty) ? F_CMD  :
              (pend_q != 4'd0)                               ? F_TRIG :
              !fifo_empty                                    ? F_CMD  :
              (sync_q >= SW'(SYNC_INTERVAL))                 ? F_SYNC : F_IDLE;
        state_d   = load ? sel : state_q;
        trig_load = load && sel == F_TRIG;
        pop       = load && sel == F_CMD;
        data_d = !load           ? data_q :
                 sel == F_TRIG   ? {8'hA5, tag_q} :
                 sel == F_CMD    ? {4'hC, mem_q[rd_ptr_q]} :
                 sel == F_SYNC   ? 16'h817E : 16'hAAAA;
        tag_d   = trig_load ? tag_q + 8'd1 : tag_q;
        burst_d = !load ? burst_q : (trig_load && !fifo_empty) ? burst_q + BW'(1) : '0;
        sync_d  = !load ? sync_q :
                  sel == F_SYNC ? '0 :
                  (sync_q >= SW'(SYNC_INTERVAL)) ? sync_q : sync_q + SW'(1);
        pend_d = pend_q;
        ovf_d  = ovf_q;
        // A trigger arriving on a TRIG load replaces the one consumed, so the count holds
        if (trig_in && !trig_load) begin
            if (pend_q == 4'hF) ovf_d = 1'b1;
            else pend_d = pend_q + 4'd1;
        end else if (!trig_in && trig_load) begin
            pend_d = pend_q - 4'd1;
        end
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= F_IDLE;
            valid_q  <= 1'b0;
            data_q   <= 16'h0000;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            sync_q   <= '0;
            burst_q  <= '0;
            tag_q    <= 8'd0;
            pend_q   <= 4'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= 1'b1;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            sync_q   <= sync_d;
            burst_q  <= burst_d;
            tag_q    <= tag_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q and the pointers
    always_ff @(posedge clk160) begin
        if (push) mem_q[wr_ptr_q] <= cmd_data;
    end

    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign trig_pending  = pend_q;
    assign trig_overflow = ovf_q;
endmodule

// File: tb/tb_ttc_frame_scheduler.sv
// tb_ttc_frame_scheduler: directed and random checks of ttc_frame_scheduler against a frame-level reference model
module tb_ttc_frame_scheduler;
    localparam int DEPTH = 4;
    localparam int SYNCI = 32;
    localparam int MAXB  = 4;

    logic        clk160 = 1'b0;
    logic        rst_n;
    logic        trig_in;
    logic        cmd_valid;
    logic [11:0] cmd_data;
    logic        cmd_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  trig_pending;
    logic        trig_overflow;

    ttc_frame_scheduler #(.CMD_DEPTH(DEPTH), .SYNC_INTERVAL(SYNCI), .MAX_TRIG_BURST(MAXB)) dut (
        .clk160(clk160), .rst_n(rst_n), .trig_in(trig_in), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .trig_pending(trig_pending), .trig_overflow(trig_overflow)
    );

    always #5 clk160 = ~clk160;

    int errors = 0;
    int checks = 0;

    // Reference model state: counts, a command queue and the frame currently presented
    int          m_pend, m_sync, m_burst;
    bit          m_ovf, m_valid;
    logic [7:0]  m_tag;
    logic [15:0] m_data;
    logic [11:0] m_q[$];

    logic [15:0] got[$];
    logic [15:0] all[$];
    int          peak;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_sync = 0; m_burst = 0; m_ovf = 0; m_valid = 0;
        m_tag = 8'd0; m_data = 16'h0000; m_q.delete();
    endtask

    task automatic model_edge(input bit t, input bit cv, input logic [11:0] cd, input bit ordy);
        bit has_cmd, is_trig, is_sync;
        int qn;
        qn = m_q.size();
        has_cmd = qn != 0;
        is_trig = 0;
        is_sync = 0;
        if (!m_valid || ordy) begin
            m_valid = 1;
            if (m_burst == MAXB && has_cmd) m_data = {4'hC, m_q.pop_front()};
            else if (m_pend > 0) begin
                m_data = {8'hA5, m_tag};
                m_tag++;
                m_pend--;
                is_trig = 1;
            end
            else if (has_cmd) m_data = {4'hC, m_q.pop_front()};
            else if (m_sync >= SYNCI) begin
                m_data = 16'h817E;
                is_sync = 1;
            end
            else m_data = 16'hAAAA;
            m_burst = (is_trig && has_cmd) ? m_burst + 1 : 0;
            m_sync = is_sync ? 0 : (m_sync < SYNCI ? m_sync + 1 : SYNCI);
        end
        if (t) begin
            if (m_pend < 15) m_pend++;
            else m_ovf = 1;
        end
        if (cv && qn < DEPTH) m_q.push_back(cd);
    endtask

    task automatic step(input bit t, input bit cv, input logic [11:0] cd, input bit ordy);
        trig_in = t; cmd_valid = cv; cmd_data = cd; out_ready = ordy;
        if (out_valid && ordy) begin
            all.push_back(out_data);
            if (out_data[15:12] == 4'hC || out_data[15:8] == 8'hA5) got.push_back(out_data);
        end
        @(posedge clk160);
        model_edge(t, cv, cd, ordy);
        #1;
        chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
        chk("out_data", out_data, m_data);
        chk("trig_pending", {12'd0, trig_pending}, 16'(m_pend));
        chk("trig_overflow", {15'd0, trig_overflow}, {15'd0, m_ovf});
        chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, m_q.size() < DEPTH});
        if (int'(trig_pending) > peak) peak = int'(trig_pending);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; trig_in = 1'b0; cmd_valid = 1'b0; cmd_data = 12'h0; out_ready = 1'b0;
        model_reset();
        @(posedge clk160);
        #1;
        chk("rst out_valid", {15'd0, out_valid}, 16'h0);
        chk("rst out_data", out_data, 16'h0000);
        chk("rst trig_pending", {12'd0, trig_pending}, 16'h0);
        chk("rst trig_overflow", {15'd0, trig_overflow}, 16'h0);
        chk("rst cmd_ready", {15'd0, cmd_ready}, 16'h1);
        rst_n = 1'b1;
        got.delete();
        all.delete();
        peak = 0;
    endtask

    initial begin
        logic [15:0] held;
        logic [15:0] exp6 [11];
        exp6 = '{16'hA500, 16'hA501, 16'hA502, 16'hA503, 16'hC0FF, 16'hA504,
                 16'hA505, 16'hA506, 16'hA507, 16'hA508, 16'hA509};

        // Idle stream and sync insertion
        do_reset();
        repeat (40) step(1'b0, 1'b0, 12'h0, 1'b1);
        chk("first idle", all[0], 16'hAAAA);
        chk("frame 33 sync", all[32], 16'h817E);
        chk("idle after sync", all[33], 16'hAAAA);

        // Three back-to-back triggers
        do_reset();
        step(1'b0, 1'b0, 12'h0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 12'h0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 12'h0, 1'b1);
        chk("trig count", 16'(got.size()), 16'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("trig tag order", got[i], 16'hA500 + 16'(i));
        chk("peak pending le 3", 16'(peak <= 3), 16'd1);
        chk("pending drained", {12'd0, trig_pending}, 16'h0);

        // Trigger ahead of two commands, then fill the FIFO with the link stalled
        do_reset();
        step(1'b0, 1'b0, 12'h0, 1'b1);
        step(1'b1, 1'b1, 12'h123, 1'b1);
        step(1'b0, 1'b1, 12'h456, 1'b1);
        repeat (6) step(1'b0, 1'b0, 12'h0, 1'b1);
        chk("mix count", 16'(got.size()), 16'd3);
        if (got.size() == 3) begin
            chk("mix 0", got[0], 16'hA500);
            chk("mix 1", got[1], 16'hC123);
            chk("mix 2", got[2], 16'hC456);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 12'h700 + 12'(i), 1'b0);
            if (i == 2) chk("ready before full", {15'd0, cmd_ready}, 16'h1);
            if (i >= 3) chk("ready when full", {15'd0, cmd_ready}, 16'h0);
        end

        // Stall with triggers arriving: frame must hold
        do_reset();
        step(1'b0, 1'b0, 12'h0, 1'b1);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            step(i[0], 1'b0, 12'h0, 1'b0);
            chk("held data", out_data, held);
            chk("held valid", {15'd0, out_valid}, 16'h1);
        end
        repeat (10) step(1'b0, 1'b0, 12'h0, 1'b1);
        chk("resume count", 16'(got.size()), 16'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("resume tag", got[i], 16'hA500 + 16'(i));

        // Trigger overflow and drain
        do_reset();
        step(1'b0, 1'b0, 12'h0, 1'b1);
        repeat (20) step(1'b1, 1'b0, 12'h0, 1'b0);
        chk("pending saturates", {12'd0, trig_pending}, 16'd15);
        chk("overflow set", {15'd0, trig_overflow}, 16'h1);
        repeat (25) step(1'b0, 1'b0, 12'h0, 1'b1);
        chk("drain count", 16'(got.size()), 16'd15);
        for (int i = 0; i < 15 && i < got.size(); i++) chk("drain tag", got[i], 16'hA500 + 16'(i));
        chk("overflow sticky", {15'd0, trig_overflow}, 16'h1);

        // Burst limit lets a waiting command through
        do_reset();
        step(1'b0, 1'b0, 12'h0, 1'b1);
        repeat (10) step(1'b1, 1'b0, 12'h0, 1'b0);
        step(1'b0, 1'b1, 12'h0FF, 1'b0);
        repeat (20) step(1'b0, 1'b0, 12'h0, 1'b1);
        chk("burst count", 16'(got.size()), 16'd11);
        for (int i = 0; i < 11 && i < got.size(); i++) chk("burst order", got[i], exp6[i]);

        // Reset in mid-stream with queued work
        do_reset();
        step(1'b0, 1'b0, 12'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'h3A0 + 12'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async rst valid", {15'd0, out_valid}, 16'h0);
        chk("async rst pending", {12'd0, trig_pending}, 16'h0);
        chk("async rst data", out_data, 16'h0000);
        do_reset();
        step(1'b0, 1'b0, 12'h0, 1'b1);
        chk("post reset idle", out_data, 16'hAAAA);
        step(1'b1, 1'b0, 12'h0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 12'h0, 1'b1);
        chk("post reset frames", 16'(got.size()), 16'd1);
        if (got.size() > 0) chk("post reset tag", got[0], 16'hA500);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 12'($urandom), $urandom_range(0, 9) < 7);
        repeat (60) step(1'b0, 1'b0, 12'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
